// File: rtl/booth_multiplier_if.sv
// Request/response bundle between the issue logic, the multiplier and the
// writeback arbiter. Signal names match the execute-stage port list.
interface booth_multiplier_if #(
   parameter int unsigned XLEN = 64
);
   logic            io_i_mul_valid;
   logic            io_o_mul_ready;
   logic            io_i_flush;
   logic            io_i_mulw;
   logic [1:0]      io_i_mul_signed;
   logic [XLEN-1:0] io_i_multiplicand;
   logic [XLEN-1:0] io_i_multiplier;
   logic            io_o_out_valid;
   logic            io_i_out_ready;
   logic [XLEN-1:0] io_o_result_hi;
   logic [XLEN-1:0] io_o_result_lo;

   modport master (
      output io_i_mul_valid, io_i_flush, io_i_mulw, io_i_mul_signed,
             io_i_multiplicand, io_i_multiplier, io_i_out_ready,
      input  io_o_mul_ready, io_o_out_valid, io_o_result_hi, io_o_result_lo
   );

   modport slave (
      input  io_i_mul_valid, io_i_flush, io_i_mulw, io_i_mul_signed,
             io_i_multiplicand, io_i_multiplier, io_i_out_ready,
      output io_o_mul_ready, io_o_out_valid, io_o_result_hi, io_o_result_lo
   );
endinterface

// File: rtl/booth_multiplier.sv
// Iterative radix-4 Booth multiplier for the EX stage: one Booth digit per
// cycle, per-operand signedness, word mode with early termination, flush.
module booth_multiplier #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned WORD = 32
) (
   input logic          clock,
   input logic          reset,
   booth_multiplier_if.slave io
);
   localparam int unsigned EW = XLEN + 2;          // extended operand width
   localparam int unsigned AW = 2 * XLEN + 4;      // accumulator width
   localparam int unsigned DF = (XLEN + 2) / 2;    // digits, full mode
   localparam int unsigned DW = (WORD + 2) / 2;    // digits, word mode
   localparam int unsigned CW = $clog2(DF + 1);
   localparam int unsigned SH = XLEN - WORD;       // word-mode product offset

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

   state_e          state_q;
   logic [EW-1:0]   mcand_q;
   logic [EW:0]     mplier_q;
   logic [AW-1:0]   acc_q;
   logic [CW-1:0]   cnt_q;
   logic            mulw_q;
   logic            out_valid_q;
   logic [XLEN-1:0] res_hi_q;
   logic [XLEN-1:0] res_lo_q;

   logic            mul_ready_c;
   logic            accept_c;
   logic            a_sgn_c;
   logic            b_sgn_c;
   logic [EW-1:0]   a_ext_c;
   logic [EW-1:0]   b_ext_c;
   logic [EW-1:0]   pp_c;
   logic [AW-1:0]   pp_sh_c;
   logic [AW-1:0]   sum_c;
   logic [AW-1:0]   acc_d;
   logic [XLEN-1:0] res_hi_d;
   logic [XLEN-1:0] res_lo_d;

   assign mul_ready_c = (state_q == IDLE) & ~io.io_i_flush;
   assign accept_c    = io.io_i_mul_valid & mul_ready_c;

   // Two-bit extension makes the most-negative and all-ones operands exact.
   always_comb begin
      a_sgn_c = io.io_i_mul_signed[1] & (io.io_i_mulw ? io.io_i_multiplicand[WORD-1]
                                                      : io.io_i_multiplicand[XLEN-1]);
      b_sgn_c = io.io_i_mul_signed[0] & (io.io_i_mulw ? io.io_i_multiplier[WORD-1]
                                                      : io.io_i_multiplier[XLEN-1]);
      if (io.io_i_mulw) begin
         a_ext_c = {{(EW-WORD){a_sgn_c}}, io.io_i_multiplicand[WORD-1:0]};
         b_ext_c = {{(EW-WORD){b_sgn_c}}, io.io_i_multiplier[WORD-1:0]};
      end else begin
         a_ext_c = {{2{a_sgn_c}}, io.io_i_multiplicand};
         b_ext_c = {{2{b_sgn_c}}, io.io_i_multiplier};
      end
   end

   // Partial product is added at bit EW so a full run leaves P at bit 0.
   always_comb begin
      pp_c = '0;
      case (mplier_q[2:0])
         3'b001, 3'b010: pp_c = mcand_q;
         3'b011:         pp_c = {mcand_q[EW-2:0], 1'b0};
         3'b100:         pp_c = -{mcand_q[EW-2:0], 1'b0};
         3'b101, 3'b110: pp_c = -mcand_q;
         default:        pp_c = '0;
      endcase
      pp_sh_c = {pp_c, {EW{1'b0}}};
      sum_c   = acc_q + pp_sh_c;
      acc_d   = $signed(sum_c) >>> 2;
   end

   // Word mode stops early, leaving Pw scaled up by SH bits.
   always_comb begin
      res_hi_d = acc_d[2*XLEN-1:XLEN];
      res_lo_d = acc_d[XLEN-1:0];
      if (mulw_q) begin
         res_hi_d = {{SH{acc_d[XLEN+WORD-1]}}, acc_d[XLEN +: WORD]};
         res_lo_d = {{SH{acc_d[SH+WORD-1]}}, acc_d[SH +: WORD]};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         mulw_q      <= 1'b0;
         out_valid_q <= 1'b0;
         res_hi_q    <= '0;
         res_lo_q    <= '0;
      end else if (io.io_i_flush) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_c) begin
                  mcand_q  <= a_ext_c;
                  mplier_q <= {b_ext_c, 1'b0};
                  acc_q    <= '0;
                  mulw_q   <= io.io_i_mulw;
                  cnt_q    <= io.io_i_mulw ? CW'(DW) : CW'(DF);
                  state_q  <= BUSY;
               end
            end
            BUSY: begin
               acc_q    <= acc_d;
               mplier_q <= {2'b00, mplier_q[EW:2]};
               cnt_q    <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  res_hi_q    <= res_hi_d;
                  res_lo_q    <= res_lo_d;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               if (io.io_i_out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign io.io_o_mul_ready = mul_ready_c;
   assign io.io_o_out_valid = out_valid_q;
   assign io.io_o_result_hi = res_hi_q;
   assign io.io_o_result_lo = res_lo_q;
endmodule
